// File: rtl/anita4_scaler_snapshot_seq.sv
`default_nettype none
// ============================================================================
// Module      : anita4_scaler_snapshot_seq
// Description : Once per PPS, walks all 36 scaler words into a double-buffered
//               snapshot the host reads at its own pace. Optional checksum
//               word at read address 36: SCALER_SNAPSHOT_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module anita4_scaler_snapshot_seq #(
    parameter int PPS_DELAY     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        pps_i,
    output logic [5:0]  scal_addr_o,
    input  logic [31:0] scal_dat_i,
    input  logic [5:0]  rd_addr_i,
    output logic [31:0] rd_dat_o,
    input  logic        rd_ack_i,
    output logic        snap_valid_o,
    output logic [7:0]  snap_seq_o,
    output logic [7:0]  overrun_o,
    output logic        busy_o
);

    localparam int               N_WORDS     = 36;
    localparam int               DLY_W       = (PPS_DELAY > 0) ? $clog2(PPS_DELAY + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST    = DLY_W'(PPS_DELAY - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0]       K_LAST      = 6'd35;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ADDR  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             pps_q;
    logic             pps_edge_q, pps_edge_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [5:0]       k_q, k_d;
    logic [3:0]       settle_q, settle_d;
    logic [5:0]       scal_addr_q, scal_addr_d;
    logic             bank_sel_q, bank_sel_d;
    logic             snap_valid_q, snap_valid_d;
    logic [7:0]       snap_seq_q, snap_seq_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic [31:0]      rd_dat_q, rd_dat_d;
    logic             bank_we;
    logic [1:0]       ovr_inc;
    logic [8:0]       ovr_sum;
    logic [31:0]      bank_q [2][N_WORDS];
`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
    logic [31:0]      csum_q, csum_d;
    logic [31:0]      csum_bank_q [2];
`endif

    // Aux words sit at 0x20,0x21,0x24,0x25: only the last two skip a gap.
    function automatic logic [5:0] word_addr(input logic [5:0] k);
        return (k < 6'd34) ? k : k + 6'd2;
    endfunction

    always_comb begin
        pps_edge_d   = pps_i & ~pps_q;
        state_d      = state_q;
        dly_d        = dly_q;
        k_d          = k_q;
        settle_d     = settle_q;
        scal_addr_d  = scal_addr_q;
        bank_sel_d   = bank_sel_q;
        snap_valid_d = snap_valid_q;
        snap_seq_d   = snap_seq_q;
        bank_we      = 1'b0;
        ovr_inc      = 2'd0;

        if (rd_ack_i) begin
            snap_valid_d = 1'b0;
        end
        if (pps_edge_q && (state_q != S_IDLE)) begin
            ovr_inc = ovr_inc + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                scal_addr_d = 6'd0;
                if (pps_edge_q) begin
                    if (PPS_DELAY == 0) begin
                        state_d  = S_ADDR;
                        k_d      = 6'd0;
                        settle_d = 4'd0;
                    end else begin
                        state_d = S_DELAY;
                        dly_d   = '0;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    state_d     = S_ADDR;
                    k_d         = 6'd0;
                    settle_d    = 4'd0;
                    scal_addr_d = 6'd0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_ADDR: begin
                if (settle_q == SETTLE_LAST) begin
                    bank_we  = 1'b1;
                    settle_d = 4'd0;
                    if (k_q == K_LAST) begin
                        state_d     = S_DONE;
                        scal_addr_d = 6'd0;
                    end else begin
                        k_d         = k_q + 6'd1;
                        scal_addr_d = word_addr(k_q + 6'd1);
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // An ack in this very clock frees the read bank, so publish wins.
                if (!snap_valid_q || rd_ack_i) begin
                    bank_sel_d   = ~bank_sel_q;
                    snap_valid_d = 1'b1;
                    snap_seq_d   = snap_seq_q + 8'd1;
                end else begin
                    ovr_inc = ovr_inc + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ovr_sum   = {1'b0, overrun_q} + {7'd0, ovr_inc};
        overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
        busy_d    = (state_d != S_IDLE);

`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
        if (state_q != S_ADDR) begin
            csum_d = 32'd0;
        end else if (bank_we) begin
            csum_d = csum_q ^ scal_dat_i;
        end else begin
            csum_d = csum_q;
        end
`endif

        rd_dat_d = 32'd0;
        if (rd_addr_i < 6'd36) begin
            rd_dat_d = bank_q[bank_sel_q][rd_addr_i];
        end
`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
        else if (rd_addr_i == 6'd36) begin
            rd_dat_d = csum_bank_q[bank_sel_q];
        end
`endif
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pps_q        <= 1'b0;
            pps_edge_q   <= 1'b0;
            dly_q        <= '0;
            k_q          <= 6'd0;
            settle_q     <= 4'd0;
            scal_addr_q  <= 6'd0;
            bank_sel_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_seq_q   <= 8'd0;
            overrun_q    <= 8'd0;
            busy_q       <= 1'b0;
            rd_dat_q     <= 32'd0;
`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
            csum_q       <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            pps_q        <= pps_i;
            pps_edge_q   <= pps_edge_d;
            dly_q        <= dly_d;
            k_q          <= k_d;
            settle_q     <= settle_d;
            scal_addr_q  <= scal_addr_d;
            bank_sel_q   <= bank_sel_d;
            snap_valid_q <= snap_valid_d;
            snap_seq_q   <= snap_seq_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            rd_dat_q     <= rd_dat_d;
`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Snapshot storage carries no reset; contents are meaningless until a publish.
    always_ff @(posedge clk33_i) begin
        if (bank_we) begin
            bank_q[~bank_sel_q][k_q] <= scal_dat_i;
        end
    end

`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
    always_ff @(posedge clk33_i) begin
        if (state_q == S_DONE) begin
            csum_bank_q[~bank_sel_q] <= csum_q;
        end
    end
`endif

    assign scal_addr_o  = scal_addr_q;
    assign rd_dat_o     = rd_dat_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_seq_o   = snap_seq_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_anita4_scaler_snapshot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_anita4_scaler_snapshot_seq
// Description : Self-checking bench for anita4_scaler_snapshot_seq against a
//               cycle-timed behavioural model of the snapshot rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anita4_scaler_snapshot_seq;

    localparam int PPS_DELAY     = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int SCAN_LAST     = 1 + PPS_DELAY + 36 * SETTLE_CYCLES;
`ifdef SCALER_SNAPSHOT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk33_i = 1'b0;
    logic        rst_i   = 1'b1;
    logic        pps_i   = 1'b0;
    logic        rd_ack_i = 1'b0;
    logic [5:0]  rd_addr_i = 6'd0;
    logic [5:0]  scal_addr_o;
    logic [31:0] scal_dat_i;
    logic [31:0] rd_dat_o;
    logic        snap_valid_o;
    logic [7:0]  snap_seq_o;
    logic [7:0]  overrun_o;
    logic        busy_o;

    bit          use_hash = 1'b0;
    logic [31:0] salt     = 32'd0;

    always #15 clk33_i = ~clk33_i;

    anita4_scaler_snapshot_seq #(
        .PPS_DELAY     (PPS_DELAY),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk33_i      (clk33_i),
        .rst_i        (rst_i),
        .pps_i        (pps_i),
        .scal_addr_o  (scal_addr_o),
        .scal_dat_i   (scal_dat_i),
        .rd_addr_i    (rd_addr_i),
        .rd_dat_o     (rd_dat_o),
        .rd_ack_i     (rd_ack_i),
        .snap_valid_o (snap_valid_o),
        .snap_seq_o   (snap_seq_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    // Scaler mux: fixed 0xA5000000|addr pattern, or a salted per-address hash.
    function automatic logic [31:0] scal_word(input logic [5:0] a, input bit h, input logic [31:0] s);
        return h ? (s ^ ({26'd0, a} * 32'h9E3779B1)) : (32'hA5000000 | {26'd0, a});
    endfunction

    assign scal_dat_i = scal_word(scal_addr_o, use_hash, salt);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle time %0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          amap [36];
    int          cyc = 0;
    bit          m_prev, m_act, m_pend, m_valid, m_has;
    int          m_t, m_seq, m_ovr;
    logic [31:0] m_cap [36];
    logic [31:0] m_bank [36];
    logic [31:0] m_cap_x, m_bank_x;
    logic [31:0] e_rd;
    bit          e_rd_chk, e_busy;
    logic [5:0]  e_addr;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge();
        int j;
        if (rst_i) begin
            m_prev = 0; m_act = 0; m_pend = 0; m_valid = 0; m_has = 0;
            m_seq = 0; m_ovr = 0;
            e_rd = 32'd0; e_rd_chk = 1; e_busy = 0; e_addr = 6'd0;
            return;
        end
        if (m_pend) begin
            m_ovr  = sat(m_ovr + 1);
            m_pend = 0;
        end
        e_rd_chk = m_has;
        if (rd_addr_i < 6'd36)       e_rd = m_bank[rd_addr_i];
        else if (rd_addr_i == 6'd36) e_rd = CSUM_EN ? m_bank_x : 32'd0;
        else                         e_rd = 32'd0;
        if (m_act && (cyc == m_t + SCAN_LAST + 1)) begin
            m_act = 0;
            if (!m_valid || rd_ack_i) begin
                m_valid = 1;
                m_seq   = (m_seq + 1) % 256;
                m_bank  = m_cap;
                m_bank_x = m_cap_x;
                m_has   = 1;
            end else begin
                m_ovr = sat(m_ovr + 1);
            end
        end else if (rd_ack_i) begin
            m_valid = 0;
        end
        if (pps_i && !m_prev) begin
            if (m_act) begin
                m_pend = 1;
            end else begin
                m_act   = 1;
                m_t     = cyc;
                m_cap_x = 32'd0;
                for (int k = 0; k < 36; k++) begin
                    m_cap[k] = scal_word(6'(amap[k]), use_hash, salt);
                    m_cap_x  = m_cap_x ^ m_cap[k];
                end
            end
        end
        m_prev = pps_i;
        e_busy = m_act && (cyc > m_t);
        j      = cyc - (m_t + 1 + PPS_DELAY);
        e_addr = (m_act && j >= 0 && j < 36 * SETTLE_CYCLES) ? 6'(amap[j / SETTLE_CYCLES]) : 6'd0;
    endtask

    task automatic step();
        @(posedge clk33_i);
        cyc++;
        model_edge();
        #1;
        check("scal_addr", 32'(scal_addr_o), 32'(e_addr));
        check("busy", 32'(busy_o), 32'(e_busy));
        check("snap_valid", 32'(snap_valid_o), 32'(m_valid));
        check("snap_seq", 32'(snap_seq_o), 32'(m_seq));
        check("overrun", 32'(overrun_o), 32'(m_ovr));
        if (e_rd_chk) check("rd_dat", rd_dat_o, e_rd);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Raises PPS so the next edge samples it high; returns that edge's index.
    task automatic pulse_pps(output int t);
        pps_i = 1'b1;
        step();
        t = cyc;
        step();
        step();
        pps_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t     rd_tab [12];
    int          t0, t1, ovr0, seq0;
    logic [31:0] xsum;

    initial begin
        for (int k = 0; k < 36; k++) amap[k] = (k < 32) ? k : 0;
        amap[32] = 32'h20; amap[33] = 32'h21; amap[34] = 32'h24; amap[35] = 32'h25;

        // Pattern A XORs to zero over all 36 words, so address 36 reads 0 either way.
        rd_tab[0]  = '{6'd0,  32'hA5000000};
        rd_tab[1]  = '{6'd1,  32'hA5000001};
        rd_tab[2]  = '{6'd15, 32'hA500000F};
        rd_tab[3]  = '{6'd16, 32'hA5000010};
        rd_tab[4]  = '{6'd31, 32'hA500001F};
        rd_tab[5]  = '{6'd32, 32'hA5000020};
        rd_tab[6]  = '{6'd33, 32'hA5000021};
        rd_tab[7]  = '{6'd34, 32'hA5000024};
        rd_tab[8]  = '{6'd35, 32'hA5000025};
        rd_tab[9]  = '{6'd36, 32'h00000000};
        rd_tab[10] = '{6'd37, 32'h00000000};
        rd_tab[11] = '{6'd63, 32'h00000000};

        // Reset state
        do_reset();
        check("reset_addr", 32'(scal_addr_o), 32'd0);
        check("reset_rd_dat", rd_dat_o, 32'd0);
        check("reset_valid", 32'(snap_valid_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);

        // Single scan with the fixed pattern
        use_hash = 1'b0;
        pulse_pps(t0);
        run_to(t0 + 1);
        check("delay_busy", 32'(busy_o), 32'd1);
        run_to(t0 + 1 + PPS_DELAY);
        check("first_addr", 32'(scal_addr_o), 32'h00);
        run_to(t0 + 1 + PPS_DELAY + 34 * SETTLE_CYCLES);
        check("addr_k34", 32'(scal_addr_o), 32'h24);
        run_to(t0 + SCAN_LAST);
        check("done_busy", 32'(busy_o), 32'd1);
        check("done_valid", 32'(snap_valid_o), 32'd0);
        run_to(t0 + SCAN_LAST + 2);
        check("pub_valid", 32'(snap_valid_o), 32'd1);
        check("pub_seq", 32'(snap_seq_o), 32'd1);
        check("pub_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 12; i++) begin
            rd_addr_i = rd_tab[i].addr;
            step();
            check($sformatf("rd_tab[%0d]", i), rd_dat_o, rd_tab[i].exp);
        end

        // Second scan without ack: discarded, bank untouched
        use_hash = 1'b1;
        salt     = 32'h1234_5678;
        pulse_pps(t0);
        run_to(t0 + SCAN_LAST + 2);
        check("discard_ovr", 32'(overrun_o), 32'd1);
        check("discard_seq", 32'(snap_seq_o), 32'd1);
        rd_addr_i = 6'd34;
        step();
        check("discard_rd34", rd_dat_o, 32'hA5000024);

        // Ack landing exactly in the DONE clock
        do_reset();
        use_hash = 1'b0;
        pulse_pps(t0);
        run_to(t0 + SCAN_LAST + 2);
        salt     = 32'hCAFE_0001;
        use_hash = 1'b1;
        pulse_pps(t0);
        run_to(t0 + SCAN_LAST);
        rd_ack_i = 1'b1;
        step();
        rd_ack_i = 1'b0;
        check("ackdone_seq", 32'(snap_seq_o), 32'd2);
        check("ackdone_valid", 32'(snap_valid_o), 32'd1);
        check("ackdone_ovr", 32'(overrun_o), 32'd0);
        rd_addr_i = 6'd5;
        step();
        check("ackdone_rd5", rd_dat_o, scal_word(6'd5, 1'b1, 32'hCAFE_0001));

        // PPS while busy: ignored, scan timing unchanged
        rd_ack_i = 1'b1;
        step();
        rd_ack_i = 1'b0;
        ovr0 = int'(overrun_o);
        seq0 = int'(snap_seq_o);
        pulse_pps(t0);
        run_to(t0 + 20);
        pps_i = 1'b1;
        step();
        step();
        pps_i = 1'b0;
        run_to(t0 + SCAN_LAST);
        check("busy_pps_busy", 32'(busy_o), 32'd1);
        step();
        check("busy_pps_idle", 32'(busy_o), 32'd0);
        check("busy_pps_ovr", 32'(overrun_o), 32'(ovr0 + 1));
        check("busy_pps_seq", 32'(snap_seq_o), 32'(seq0 + 1));

        // Reset while word 10 is on the bus, then a clean scan
        salt = 32'h0BAD_F00D;
        pulse_pps(t0);
        run_to(t0 + 1 + PPS_DELAY + 10 * SETTLE_CYCLES);
        check("k10_addr", 32'(scal_addr_o), 32'd10);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("k10_rst_addr", 32'(scal_addr_o), 32'd0);
        check("k10_rst_busy", 32'(busy_o), 32'd0);
        check("k10_rst_seq", 32'(snap_seq_o), 32'd0);
        check("k10_rst_ovr", 32'(overrun_o), 32'd0);
        check("k10_rst_rd", rd_dat_o, 32'd0);
        step();
        salt = 32'h5EED_1234;
        pulse_pps(t1);
        run_to(t1 + SCAN_LAST + 2);
        check("k10_valid", 32'(snap_valid_o), 32'd1);
        check("k10_seq", 32'(snap_seq_o), 32'd1);
        rd_addr_i = 6'd10;
        step();
        check("k10_rd10", rd_dat_o, scal_word(6'd10, 1'b1, 32'h5EED_1234));
        xsum = 32'd0;
        for (int k = 0; k < 36; k++) xsum = xsum ^ scal_word(6'(amap[k]), 1'b1, 32'h5EED_1234);
        rd_addr_i = 6'd36;
        step();
        check("rd36", rd_dat_o, CSUM_EN ? xsum : 32'd0);

        // Randomised traffic against the model
        begin
            int until_pps = 10;
            int hi = 0;
            for (int c = 0; c < 4000; c++) begin
                if (hi > 0) begin
                    pps_i = 1'b1;
                    hi--;
                end else if (until_pps == 0) begin
                    pps_i = 1'b1;
                    hi = 2;
                    until_pps = $urandom_range(5, 160);
                end else begin
                    pps_i = 1'b0;
                    until_pps--;
                end
                if (!m_act && !pps_i) salt = $urandom;
                rd_ack_i  = ($urandom_range(0, 39) == 0);
                rd_addr_i = 6'($urandom_range(0, 63));
                step();
            end
            pps_i    = 1'b0;
            rd_ack_i = 1'b0;
            run_to(cyc + SCAN_LAST + 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
